rf_access_ctrl: RTL
===================

// Module: rf_access_ctrl
// PURPOSE
//  Initiator side of the register-file READ/WRITE interface. Accepts one request per
//  transaction from the CPU control FSM (valid/ready), drives READ/WRITE/ADDR/DATA_W
//  toward REGISTER_FILE_32x32, captures DATA_R1/DATA_R2 and returns a one-cycle response.
//  Guarantees READ and WRITE are never high together. Read always precedes write.
// PARAMETERS
//  DATA_WIDTH      32  width of register data
//  REG_ADDR_WIDTH  5   width of register address (32 registers)
// PORTS
//  CLK          in   1   clock; all state changes on posedge
//  RST          in   1   asynchronous, active-low reset
//  REQ_VALID    in   1   request present
//  REQ_READY    out  1   controller idle and accepting
//  REQ_RD_EN    in   1   request reads ADDR_R1/ADDR_R2
//  REQ_WR_EN    in   1   request writes REQ_DATA_W to ADDR_W
//  REQ_ADDR_R1  in   5   read address 1
//  REQ_ADDR_R2  in   5   read address 2
//  REQ_ADDR_W   in   5   write address
//  REQ_DATA_W   in   32  write data
//  RF_READ      out  1   to register file READ
//  RF_WRITE     out  1   to register file WRITE
//  RF_ADDR_R1   out  5   to ADDR_R1 (latched request)
//  RF_ADDR_R2   out  5   to ADDR_R2 (latched request)
//  RF_ADDR_W    out  5   to ADDR_W (latched request)
//  RF_DATA_W    out  32  to DATA_W (latched request)
//  RF_DATA_R1   in   32  from DATA_R1
//  RF_DATA_R2   in   32  from DATA_R2
//  RSP_VALID    out  1   transaction complete, one-cycle pulse
//  RSP_DATA_R1  out  32  captured read data 1
//  RSP_DATA_R2  out  32  captured read data 2
// BEHAVIOUR
//  States: IDLE, READ, CAPT, WRITE, DONE (registered, reset to IDLE).
//  Reset (RST=0): state IDLE; all latched addr/data, RSP_DATA_R*, RSP_VALID, RF_READ,
//   RF_WRITE = 0; REQ_READY = RST & (state==IDLE), so 0 while reset held.
//  IDLE: REQ_READY=1. Accept on posedge with REQ_VALID=1: latch all REQ_* fields;
//   next = READ if RD_EN, else WRITE if WR_EN, else DONE (null request still responds).
//  READ: RF_READ=1 for exactly one cycle; RF latches DATA_R* at the ending posedge -> CAPT.
//  CAPT: RF_READ=0; at ending posedge RSP_DATA_R1/R2 <= RF_DATA_R1/R2; next WRITE if WR_EN else DONE.
//  WRITE: RF_WRITE=1 for exactly one cycle, RF_READ=0 -> DONE.
//  DONE: RSP_VALID=1 for one cycle -> IDLE. REQ_READY=0 in every non-IDLE state.
//  Latency accept->RSP_VALID: rd+wr 4 cycles, rd only 3, wr only 2, null 1.
//  Same-register read+write in one request returns the OLD value (read-before-write).
//  RSP_DATA_R* hold their value until the next CAPT; write-only requests leave them unchanged.
//  RF_ADDR_*/RF_DATA_W are driven from latches, stable across the whole transaction.
//  Reset mid-transaction: RF_READ/RF_WRITE drop asynchronously; no RSP_VALID; request lost.
//  REQ_* changes while REQ_READY=0 are ignored.
// CONFIGURATION
//  `RF_R0_PROTECT_EN defined: request with WR_EN and ADDR_W==0 skips WRITE (RF_WRITE never
//   asserted, latency as if WR_EN=0); a read address of 0 yields RSP_DATA_R*=0 regardless of RF.
//  Not defined: address 0 treated like any other register; writes and reads pass through.
// STRUCTURE
//  prj_definition.v: DATA_INDEX_LIMIT, REG_ADDR_INDEX_LIMIT reused; add 3-bit state encodings
//   `RFC_ST_IDLE/READ/CAPT/WRITE/DONE (0..4).
//  Single flat module: one state register, one request latch, one response latch; no sub-module.
// TESTING (bench instantiates this block driving REGISTER_FILE_32x32_BEHAVIORAL)
//  Reset: RST=0 mid-WRITE -> RF_WRITE=0 same time step, no RSP_VALID, state IDLE, REQ_READY=1 after release.
//  Write-only ADDR_W=5, DATA_W=32'hDEADBEEF -> RF_WRITE high exactly 1 cycle, RSP_VALID 2 cycles after accept.
//  Read R1=5,R2=0 after above -> RSP_DATA_R1=32'hDEADBEEF, RSP_DATA_R2=0, RSP_VALID 3 cycles after accept.
//  rd+wr R1=5, W=5, DATA_W=32'h12345678 -> RSP_DATA_R1=32'hDEADBEEF; later read of 5 -> 32'h12345678.
//  Back-to-back REQ_VALID held high -> REQ_READY=0 until after DONE; RF_READ&RF_WRITE never both 1 (assertion).
//  `RF_R0_PROTECT_EN: write W=0, DATA_W=32'hFFFFFFFF -> RF_WRITE stays 0; read R1=0 -> RSP_DATA_R1=0.

Source files
------------

// File: rtl/rf_access_ctrl_pkg.sv
// Shared widths, FSM state encoding and helpers for the register-file access controller.
package rf_access_ctrl_pkg;

    localparam int unsigned DefDataWidth    = 32;
    localparam int unsigned DefRegAddrWidth = 5;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRead  = 3'd1,
        StCapt  = 3'd2,
        StWrite = 3'd3,
        StDone  = 3'd4
    } state_e;

    function automatic state_e post_read_state(input logic wr_en);
        return wr_en ? StWrite : StDone;
    endfunction

endpackage

// File: rtl/rf_access_ctrl.sv
// Register-file initiator: one request per transaction, read strictly before write.
// Optional `RF_R0_PROTECT_EN makes register 0 read as zero and ignore writes.
module rf_access_ctrl
    import rf_access_ctrl_pkg::*;
#(
    parameter int unsigned DataWidth    = DefDataWidth,
    parameter int unsigned RegAddrWidth = DefRegAddrWidth
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_rd_en_i,
    input  logic                    req_wr_en_i,
    input  logic [RegAddrWidth-1:0] req_addr_r1_i,
    input  logic [RegAddrWidth-1:0] req_addr_r2_i,
    input  logic [RegAddrWidth-1:0] req_addr_w_i,
    input  logic [DataWidth-1:0]    req_data_w_i,
    output logic                    rf_read_o,
    output logic                    rf_write_o,
    output logic [RegAddrWidth-1:0] rf_addr_r1_o,
    output logic [RegAddrWidth-1:0] rf_addr_r2_o,
    output logic [RegAddrWidth-1:0] rf_addr_w_o,
    output logic [DataWidth-1:0]    rf_data_w_o,
    input  logic [DataWidth-1:0]    rf_data_r1_i,
    input  logic [DataWidth-1:0]    rf_data_r2_i,
    output logic                    rsp_valid_o,
    output logic [DataWidth-1:0]    rsp_data_r1_o,
    output logic [DataWidth-1:0]    rsp_data_r2_o
);

    state_e                  state_q, state_d;
    logic                    wr_en_q, wr_en_d;
    logic [RegAddrWidth-1:0] addr_r1_q, addr_r1_d;
    logic [RegAddrWidth-1:0] addr_r2_q, addr_r2_d;
    logic [RegAddrWidth-1:0] addr_w_q, addr_w_d;
    logic [DataWidth-1:0]    data_w_q, data_w_d;
    logic [DataWidth-1:0]    rsp_r1_q, rsp_r1_d;
    logic [DataWidth-1:0]    rsp_r2_q, rsp_r2_d;
    logic                    wr_req;
    logic [DataWidth-1:0]    rd_data_r1, rd_data_r2;

`ifdef RF_R0_PROTECT_EN
    // A write to register 0 is dropped at accept, so it costs no WRITE cycle.
    assign wr_req     = req_wr_en_i && (req_addr_w_i != '0);
    assign rd_data_r1 = (addr_r1_q == '0) ? '0 : rf_data_r1_i;
    assign rd_data_r2 = (addr_r2_q == '0) ? '0 : rf_data_r2_i;
`else
    assign wr_req     = req_wr_en_i;
    assign rd_data_r1 = rf_data_r1_i;
    assign rd_data_r2 = rf_data_r2_i;
`endif

    always_comb begin
        state_d   = state_q;
        wr_en_d   = wr_en_q;
        addr_r1_d = addr_r1_q;
        addr_r2_d = addr_r2_q;
        addr_w_d  = addr_w_q;
        data_w_d  = data_w_q;
        rsp_r1_d  = rsp_r1_q;
        rsp_r2_d  = rsp_r2_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    wr_en_d   = wr_req;
                    addr_r1_d = req_addr_r1_i;
                    addr_r2_d = req_addr_r2_i;
                    addr_w_d  = req_addr_w_i;
                    data_w_d  = req_data_w_i;
                    if (req_rd_en_i) begin
                        state_d = StRead;
                    end else if (wr_req) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StRead: state_d = StCapt;
            StCapt: begin
                rsp_r1_d = rd_data_r1;
                rsp_r2_d = rd_data_r2;
                state_d  = post_read_state(wr_en_q);
            end
            StWrite: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            wr_en_q   <= 1'b0;
            addr_r1_q <= '0;
            addr_r2_q <= '0;
            addr_w_q  <= '0;
            data_w_q  <= '0;
            rsp_r1_q  <= '0;
            rsp_r2_q  <= '0;
        end else begin
            state_q   <= state_d;
            wr_en_q   <= wr_en_d;
            addr_r1_q <= addr_r1_d;
            addr_r2_q <= addr_r2_d;
            addr_w_q  <= addr_w_d;
            data_w_q  <= data_w_d;
            rsp_r1_q  <= rsp_r1_d;
            rsp_r2_q  <= rsp_r2_d;
        end
    end

    // Strobes decode straight from the state register, so reset drops them immediately.
    assign req_ready_o   = rst_ni && (state_q == StIdle);
    assign rf_read_o     = (state_q == StRead);
    assign rf_write_o    = (state_q == StWrite);
    assign rsp_valid_o   = (state_q == StDone);
    assign rf_addr_r1_o  = addr_r1_q;
    assign rf_addr_r2_o  = addr_r2_q;
    assign rf_addr_w_o   = addr_w_q;
    assign rf_data_w_o   = data_w_q;
    assign rsp_data_r1_o = rsp_r1_q;
    assign rsp_data_r2_o = rsp_r2_q;

endmodule
